rs_alu: RTL and testbench

RS_ALU -- requirements
Module: rs_alu

---
 rtl/rs_alu_if.sv | 34 +++
 rtl/rs_alu.sv | 180 ++++++++++++++++++
 tb/tb_rs_alu.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch bundle into the ALU reservation station.
// full back-pressures dispatch_valid.
interface rs_alu_if #(
   parameter int ROB_WIDTH = 4
);
   logic                 dispatch_valid;
   logic [4:0]           dispatch_op;
   logic [ROB_WIDTH-1:0] dispatch_rob_id;
   logic [31:0]          dispatch_true_jaddr;
   logic [31:0]          dispatch_false_jaddr;
   logic [31:0]          dispatch_vj;
   logic                 dispatch_qj_valid;
   logic [ROB_WIDTH-1:0] dispatch_qj;
   logic [31:0]          dispatch_vk;
   logic                 dispatch_qk_valid;
   logic [ROB_WIDTH-1:0] dispatch_qk;
   logic                 full;

   modport master (
      output dispatch_valid, dispatch_op, dispatch_rob_id,
      output dispatch_true_jaddr, dispatch_false_jaddr,
      output dispatch_vj, dispatch_qj_valid, dispatch_qj,
      output dispatch_vk, dispatch_qk_valid, dispatch_qk,
      input  full
   );

   modport slave (
      input  dispatch_valid, dispatch_op, dispatch_rob_id,
      input  dispatch_true_jaddr, dispatch_false_jaddr,
      input  dispatch_vj, dispatch_qj_valid, dispatch_qj,
      input  dispatch_vk, dispatch_qk_valid, dispatch_qk,
      output full
   );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station, index-priority dispatch and issue.
// Define RS_CDB_WAKEUP_EN to issue a CDB-woken entry in the same cycle.
module rs_alu #(
   parameter int RS_SIZE   = 8,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear,
   rs_alu_if.slave              disp,
   input  logic                 alu_ready,
   input  logic [ROB_WIDTH-1:0] alu_rob_id,
   input  logic [31:0]          alu_value,
   input  logic                 lsb_ready,
   input  logic [ROB_WIDTH-1:0] lsb_rob_id,
   input  logic [31:0]          lsb_value,
   output logic                 calc_enable,
   output logic [31:0]          lhs,
   output logic [31:0]          rhs,
   output logic [4:0]           op,
   output logic [ROB_WIDTH-1:0] rob_dep,
   output logic [31:0]          true_jaddr,
   output logic [31:0]          false_jaddr
);
   localparam int IW = $clog2(RS_SIZE);

   typedef logic [ROB_WIDTH-1:0] tag_t;

   typedef struct packed {
      logic        busy;
      logic [4:0]  op;
      logic [31:0] vj;
      logic        qjv;
      tag_t        qj;
      logic [31:0] vk;
      logic        qkv;
      tag_t        qk;
      tag_t        rob;
      logic [31:0] tj;
      logic [31:0] fj;
   } ent_t;

   typedef struct packed {
      logic        ce;
      logic [31:0] lhs;
      logic [31:0] rhs;
      logic [4:0]  op;
      tag_t        rob;
      logic [31:0] tj;
      logic [31:0] fj;
   } iss_t;

   ent_t ent_q [RS_SIZE];
   ent_t ent_w [RS_SIZE];
   ent_t ent_d [RS_SIZE];
   ent_t new_e;
   iss_t iss_q, iss_d;

   logic [RS_SIZE-1:0] busy_v;
   logic [RS_SIZE-1:0] rdy_v;
   logic [IW-1:0]      iss_idx;
   logic [IW-1:0]      free_idx;
   logic               iss_hit;
   logic               accept;

   // Returns {still_pending, value}; the ALU bus wins a tag tie.
   function automatic logic [32:0] snoop(
      input logic        pend,
      input tag_t        q,
      input logic [31:0] v,
      input logic        ar,
      input tag_t        at,
      input logic [31:0] av,
      input logic        lr,
      input tag_t        lt,
      input logic [31:0] lv
   );
      if (pend && ar && q == at) return {1'b0, av};
      if (pend && lr && q == lt) return {1'b0, lv};
      return {pend, v};
   endfunction

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         ent_w[i] = ent_q[i];
         {ent_w[i].qjv, ent_w[i].vj} = snoop(
            ent_q[i].qjv, ent_q[i].qj, ent_q[i].vj,
            alu_ready, alu_rob_id, alu_value,
            lsb_ready, lsb_rob_id, lsb_value);
         {ent_w[i].qkv, ent_w[i].vk} = snoop(
            ent_q[i].qkv, ent_q[i].qk, ent_q[i].vk,
            alu_ready, alu_rob_id, alu_value,
            lsb_ready, lsb_rob_id, lsb_value);
         busy_v[i] = ent_q[i].busy;
`ifdef RS_CDB_WAKEUP_EN
         rdy_v[i] = ent_w[i].busy & ~ent_w[i].qjv & ~ent_w[i].qkv;
`else
         rdy_v[i] = ent_q[i].busy & ~ent_q[i].qjv & ~ent_q[i].qkv;
`endif
      end
   end

   // Downward scan leaves the lowest matching index.
   always_comb begin
      iss_hit  = 1'b0;
      iss_idx  = '0;
      free_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (rdy_v[i]) begin
            iss_hit = 1'b1;
            iss_idx = IW'(i);
         end
         if (!busy_v[i]) free_idx = IW'(i);
      end
   end

   assign disp.full = &busy_v;
   assign accept    = disp.dispatch_valid & ~disp.full & ~clear;

   always_comb begin
      new_e.busy = 1'b1;
      new_e.op   = disp.dispatch_op;
      new_e.qj   = disp.dispatch_qj;
      new_e.qk   = disp.dispatch_qk;
      new_e.rob  = disp.dispatch_rob_id;
      new_e.tj   = disp.dispatch_true_jaddr;
      new_e.fj   = disp.dispatch_false_jaddr;
      {new_e.qjv, new_e.vj} = snoop(
         disp.dispatch_qj_valid, disp.dispatch_qj, disp.dispatch_vj,
         alu_ready, alu_rob_id, alu_value,
         lsb_ready, lsb_rob_id, lsb_value);
      {new_e.qkv, new_e.vk} = snoop(
         disp.dispatch_qk_valid, disp.dispatch_qk, disp.dispatch_vk,
         alu_ready, alu_rob_id, alu_value,
         lsb_ready, lsb_rob_id, lsb_value);
   end

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) ent_d[i] = ent_w[i];
      if (iss_hit) ent_d[iss_idx].busy = 1'b0;
      if (accept)  ent_d[free_idx] = new_e;
   end

   always_comb begin
      iss_d = '0;
      if (iss_hit) begin
         iss_d.ce  = 1'b1;
         iss_d.lhs = ent_w[iss_idx].vj;
         iss_d.rhs = ent_w[iss_idx].vk;
         iss_d.op  = ent_w[iss_idx].op;
         iss_d.rob = ent_w[iss_idx].rob;
         iss_d.tj  = ent_w[iss_idx].tj;
         iss_d.fj  = ent_w[iss_idx].fj;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
         iss_q <= '0;
      end else if (rdy_in) begin
         if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
            iss_q <= '0;
         end else begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
            iss_q <= iss_d;
         end
      end
   end

   assign calc_enable = iss_q.ce;
   assign lhs         = iss_q.lhs;
   assign rhs         = iss_q.rhs;
   assign op          = iss_q.op;
   assign rob_dep     = iss_q.rob;
   assign true_jaddr  = iss_q.tj;
   assign false_jaddr = iss_q.fj;
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed scenarios plus random traffic against
// an array-based reservation-station model.
module tb_rs_alu;
   localparam int RS = 8;
   localparam int RW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, rdy, clr;
   logic          alu_ready, lsb_ready;
   logic [RW-1:0] alu_rob_id, lsb_rob_id;
   logic [31:0]   alu_value, lsb_value;
   logic          calc_enable;
   logic [31:0]   lhs, rhs, tja, fja;
   logic [4:0]    op;
   logic [RW-1:0] rob_dep;

   rs_alu_if #(.ROB_WIDTH(RW)) dif ();

   rs_alu #(.RS_SIZE(RS), .ROB_WIDTH(RW)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
      .disp(dif),
      .alu_ready(alu_ready), .alu_rob_id(alu_rob_id),
      .alu_value(alu_value),
      .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id),
      .lsb_value(lsb_value),
      .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs), .op(op),
      .rob_dep(rob_dep), .true_jaddr(tja), .false_jaddr(fja)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          busy, pj, pk;
      logic [4:0]    op;
      logic [31:0]   vj, vk, tj, fj;
      logic [RW-1:0] qj, qk, rob;
   } m_t;

   m_t m [RS];
   logic          e_ce;
   logic [31:0]   e_lhs, e_rhs, e_tj, e_fj;
   logic [4:0]    e_op;
   logic [RW-1:0] e_rob;

   function automatic void zero_exp();
      e_ce = 0; e_lhs = 0; e_rhs = 0; e_op = 0;
      e_rob = 0; e_tj = 0; e_fj = 0;
   endfunction

   // Operand pick-up from the result buses; ALU first.
   function automatic void look(inout logic p, input logic [RW-1:0] q,
                                inout logic [31:0] v);
      if (!p) return;
      if (alu_ready && q == alu_rob_id) begin
         v = alu_value; p = 0;
      end else if (lsb_ready && q == lsb_rob_id) begin
         v = lsb_value; p = 0;
      end
   endfunction

   task automatic tick();
      int nb, fi, ii;
      logic ok, p;
      logic [31:0] v;
      m_t e;
      nb = 0;
      foreach (m[i]) if (m[i].busy) nb++;
      chk("full", 64'(dif.full), 64'(nb == RS));
      if (rst) begin
         foreach (m[i]) m[i].busy = 0;
         zero_exp();
      end else if (rdy) begin
         if (clr) begin
            foreach (m[i]) m[i].busy = 0;
            zero_exp();
         end else begin
            fi = -1; ii = -1;
            for (int i = 0; i < RS; i++)
               if (!m[i].busy && fi < 0) fi = i;
            for (int i = 0; i < RS; i++) begin
               ok = m[i].busy && !m[i].pj && !m[i].pk;
               p = m[i].pj; v = m[i].vj; look(p, m[i].qj, v);
               m[i].pj = p; m[i].vj = v;
               p = m[i].pk; v = m[i].vk; look(p, m[i].qk, v);
               m[i].pk = p; m[i].vk = v;
`ifdef RS_CDB_WAKEUP_EN
               ok = m[i].busy && !m[i].pj && !m[i].pk;
`endif
               if (ok && ii < 0) ii = i;
            end
            zero_exp();
            if (ii >= 0) begin
               e_ce = 1; e_lhs = m[ii].vj; e_rhs = m[ii].vk;
               e_op = m[ii].op; e_rob = m[ii].rob;
               e_tj = m[ii].tj; e_fj = m[ii].fj;
               m[ii].busy = 0;
            end
            if (dif.dispatch_valid && fi >= 0) begin
               e.busy = 1; e.op = dif.dispatch_op;
               e.rob = dif.dispatch_rob_id;
               e.tj = dif.dispatch_true_jaddr;
               e.fj = dif.dispatch_false_jaddr;
               e.qj = dif.dispatch_qj; e.qk = dif.dispatch_qk;
               p = dif.dispatch_qj_valid; v = dif.dispatch_vj;
               look(p, e.qj, v); e.pj = p; e.vj = v;
               p = dif.dispatch_qk_valid; v = dif.dispatch_vk;
               look(p, e.qk, v); e.pk = p; e.vk = v;
               m[fi] = e;
            end
         end
      end
      @(posedge clk); #1;
      chk("calc_enable", 64'(calc_enable), 64'(e_ce));
      chk("lhs", 64'(lhs), 64'(e_lhs));
      chk("rhs", 64'(rhs), 64'(e_rhs));
      chk("op", 64'(op), 64'(e_op));
      chk("rob_dep", 64'(rob_dep), 64'(e_rob));
      chk("true_jaddr", 64'(tja), 64'(e_tj));
      chk("false_jaddr", 64'(fja), 64'(e_fj));
   endtask

   task automatic idle();
      rst = 0; rdy = 1; clr = 0;
      dif.dispatch_valid = 0;
      alu_ready = 0; lsb_ready = 0;
   endtask

   task automatic dsp(input logic [4:0] o, input logic [31:0] vj,
                      input logic pj, input logic [RW-1:0] qj,
                      input logic [31:0] vk, input logic pk,
                      input logic [RW-1:0] qk, input logic [RW-1:0] rob);
      dif.dispatch_valid = 1; dif.dispatch_op = o;
      dif.dispatch_vj = vj; dif.dispatch_qj_valid = pj;
      dif.dispatch_qj = qj;
      dif.dispatch_vk = vk; dif.dispatch_qk_valid = pk;
      dif.dispatch_qk = qk;
      dif.dispatch_rob_id = rob;
      dif.dispatch_true_jaddr = 32'h1000 + 32'(rob);
      dif.dispatch_false_jaddr = 32'h2000 + 32'(rob);
   endtask

   task automatic flush();
      idle(); clr = 1; tick(); clr = 0;
   endtask

   initial begin
      int k;
      foreach (m[i]) m[i].busy = 0;
      zero_exp();
      idle();
      alu_rob_id = 0; alu_value = 0; lsb_rob_id = 0; lsb_value = 0;
      dsp(0, 0, 0, 0, 0, 0, 0, 0); dif.dispatch_valid = 0;
      rst = 1;
      @(posedge clk); #1;
      chk("rst_ce", 64'(calc_enable), 0);
      chk("rst_lhs", 64'(lhs), 0);
      rst = 0;
      chk("rst_full", 64'(dif.full), 0);

      // ADD 5+7, no deps
      dsp(5'b00000, 5, 0, 0, 7, 0, 0, 1); tick();
      dif.dispatch_valid = 0; tick();
      chk("add_ce", 64'(calc_enable), 1);
      chk("add_lhs", 64'(lhs), 5);
      chk("add_rhs", 64'(rhs), 7);
      chk("add_op", 64'(op), 0);
      tick();
      chk("add_ce_low", 64'(calc_enable), 0);

      // operand j waits on rob 3
      flush();
      dsp(5'd2, 0, 1, 3, 1, 0, 0, 2); tick();
      dif.dispatch_valid = 0; tick(); tick();
      alu_ready = 1; alu_rob_id = 3; alu_value = 32'h10;
`ifdef RS_CDB_WAKEUP_EN
      tick();
      chk("wake_ce", 64'(calc_enable), 1);
      chk("wake_lhs", 64'(lhs), 32'h10);
`else
      tick();
      chk("wake_early", 64'(calc_enable), 0);
      alu_ready = 0; tick();
      chk("wake_ce", 64'(calc_enable), 1);
      chk("wake_lhs", 64'(lhs), 32'h10);
`endif
      alu_ready = 0;

      // fill all entries behind rob 9
      flush();
      for (int i = 0; i < RS; i++) begin
         dsp(5'd1, 0, 1, 9, 32'(i), 0, 0, RW'(i)); tick();
      end
      chk("full_set", 64'(dif.full), 1);
      dsp(5'd1, 0, 1, 9, 99, 0, 0, 4'hF); tick();
      dif.dispatch_valid = 0;
      lsb_ready = 1; lsb_rob_id = 9; lsb_value = 32'h55;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         lsb_ready = 0;
         if (calc_enable) begin
            chk("order", 64'(rob_dep), 64'(k));
            chk("fill_lhs", 64'(lhs), 32'h55);
            if (k == 0) chk("full_fall", 64'(dif.full), 0);
            k++;
         end
      end
      chk("issue_count", 64'(k), 64'(RS));

      // dispatch catches lsb result same cycle
      flush();
      dsp(5'd3, 2, 0, 0, 0, 1, 4, 5);
      lsb_ready = 1; lsb_rob_id = 4; lsb_value = 32'hAB;
      tick();
      idle(); tick();
      chk("byp_ce", 64'(calc_enable), 1);
      chk("byp_rhs", 64'(rhs), 32'hAB);

      // flush with pending entries
      flush();
      for (int i = 0; i < 3; i++) begin
         dsp(5'd4, 1, 1, 15, 2, 0, 0, RW'(i)); tick();
      end
      dsp(5'd4, 1, 0, 0, 2, 0, 0, 7); clr = 1; tick();
      chk("clr_ce", 64'(calc_enable), 0);
      chk("clr_full", 64'(dif.full), 0);
      idle(); lsb_ready = 1; lsb_rob_id = 15; tick(); lsb_ready = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("clr_quiet", 64'(calc_enable), 0);
      end

      // freeze under rdy_in=0
      flush();
      dsp(5'd6, 32'h77, 0, 0, 0, 0, 0, 1); tick();
      dsp(5'd6, 32'h88, 0, 0, 0, 0, 0, 2); tick();
      chk("frz_first", 64'(lhs), 32'h77);
      dif.dispatch_valid = 0; rdy = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("frz_ce", 64'(calc_enable), 1);
         chk("frz_lhs", 64'(lhs), 32'h77);
      end
      rdy = 1; tick();
      chk("frz_resume", 64'(lhs), 32'h88);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         rdy = ($urandom_range(0, 7) != 0);
         clr = ($urandom_range(0, 63) == 0);
         dsp(5'($urandom), $urandom, 1'($urandom),
             RW'($urandom_range(0, 7)), $urandom, 1'($urandom),
             RW'($urandom_range(0, 7)), RW'($urandom));
         dif.dispatch_valid = 1'($urandom);
         alu_ready = ($urandom_range(0, 9) < 4);
         alu_rob_id = RW'($urandom_range(0, 7));
         alu_value = $urandom;
         lsb_ready = ($urandom_range(0, 9) < 4);
         lsb_rob_id = RW'($urandom_range(0, 7));
         lsb_value = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
